// File: rtl/uart_pkg.sv
// Shared UART-side types and helpers.
// Arbiter state, byte width and round-robin index step.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  // Step a round-robin index; wraps from n-1 to 0 explicitly so
  // non-power-of-two requester counts never visit unused slots.
  function automatic int unsigned rr_next(
    input int unsigned idx,
    input int unsigned n
  );
    if (idx + 1 >= n) begin
      return 0;
    end
    return idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// AXI-stream bundle between N requesters and the uart byte input.
// slave: arbiter view; master: requester/uart side view.
interface uart_tx_arbiter_if #(
  parameter int N = 3
);
  import uart_pkg::*;

  logic [UART_BYTE_W*N-1:0] s_axis_tdata;
  logic [N-1:0]             s_axis_tvalid;
  logic [N-1:0]             s_axis_tready;
  logic [N-1:0]             s_axis_tlast;
  logic [UART_BYTE_W-1:0]   m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    output s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority selector.
// Scans req from ptr upward, wrapping at N, returns first hit.
module rr_pick #(
  parameter int N   = 3,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    int c;
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) begin
        c = c - N;
      end
      if (req[c]) begin
        found = 1'b1;
        idx   = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the uart byte port.
// Optional stats ports: define UART_TX_ARB_STATS_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N       = 3,
  parameter int IDW     = 2,
  parameter int MAX_PKT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_arbiter_if.slave bus,
  output logic [IDW-1:0] grant_id,
  output logic           busy
`ifdef UART_TX_ARB_STATS_EN
  ,
  output logic [16*N-1:0] pkt_count,
  output logic            force_release
`endif
);

  localparam int CW = (MAX_PKT > 0) ? $clog2(MAX_PKT + 1) : 1;

  arb_state_t             state;
  arb_state_t             state_nx;
  logic [IDW-1:0]         ptr;
  logic [CW-1:0]          cnt;
  logic                   pick_found;
  logic [IDW-1:0]         pick_idx;
  logic [UART_BYTE_W-1:0] out_data;
  logic                   out_valid;
  logic [N-1:0]           ready;
  logic [UART_BYTE_W-1:0] sel_data;
  logic                   sel_valid;
  logic                   sel_last;
  logic                   load;
  logic                   accept;
  logic                   limit_hit;
  logic                   done;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req   (bus.s_axis_tvalid),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign load      = !out_valid | bus.m_axis_tready;
  assign sel_valid = bus.s_axis_tvalid[grant_id];
  assign sel_last  = bus.s_axis_tlast[grant_id];
  assign sel_data  =
    bus.s_axis_tdata[UART_BYTE_W*grant_id +: UART_BYTE_W];
  assign accept    = (state == ARB_GRANT) & load & sel_valid;
  assign done      = accept & (sel_last | limit_hit);

  // cnt holds beats already accepted; this beat is the last allowed.
  generate
    if (MAX_PKT > 0) begin : g_limit
      assign limit_hit = (cnt == CW'(MAX_PKT - 1));
    end else begin : g_nolimit
      assign limit_hit = 1'b0;
    end
  endgenerate

  // Only the granted port sees ready, and only when the
  // output register can take a byte this cycle.
  always_comb begin
    ready = '0;
    if (state == ARB_GRANT && load) begin
      ready[grant_id] = 1'b1;
    end
  end

  assign bus.s_axis_tready = ready;
  assign bus.m_axis_tdata  = out_data;
  assign bus.m_axis_tvalid = out_valid;
  assign busy              = (state == ARB_GRANT);

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: grant on any request, release on tlast or limit.
  always_comb begin
    state_nx = state;
    unique case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_nx = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (done) begin
          state_nx = ARB_IDLE;
        end
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  // Grant index, round-robin pointer and per-grant beat count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id <= '0;
      ptr      <= '0;
      cnt      <= '0;
    end else begin
      if (state == ARB_IDLE && pick_found) begin
        grant_id <= pick_idx;
      end
      if (done) begin
        ptr <= IDW'(rr_next(32'(grant_id), N));
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Registered output stage toward the uart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= accept;
      if (accept) begin
        out_data <= sel_data;
      end
    end
  end

`ifdef UART_TX_ARB_STATS_EN
  // Completed-grant counters and limit-release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count     <= '0;
      force_release <= 1'b0;
    end else begin
      force_release <= done & !sel_last;
      if (done) begin
        pkt_count[16*grant_id +: 16] <=
          pkt_count[16*grant_id +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a packet-level model.
// N=3, MAX_PKT=4; stats checks when UART_TX_ARB_STATS_EN is defined.
module tb_uart_tx_arbiter;

  localparam int NP   = 3;
  localparam int MAXP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N(NP)) bus ();

  logic [1:0]  grant_id;
  logic        busy;
  logic [23:0] td = '0;
  logic [2:0]  tv = '0;
  logic [2:0]  tl = '0;
  logic        mr = 1'b0;
  logic [2:0]  tr_obs;
  logic        mv;
  logic [7:0]  md;

`ifdef UART_TX_ARB_STATS_EN
  logic [47:0] pkt_count;
  logic        force_release;
`endif

  assign bus.s_axis_tdata  = td;
  assign bus.s_axis_tvalid = tv;
  assign bus.s_axis_tlast  = tl;
  assign bus.m_axis_tready = mr;
  assign tr_obs = bus.s_axis_tready;
  assign mv     = bus.m_axis_tvalid;
  assign md     = bus.m_axis_tdata;

  uart_tx_arbiter #(
    .N       (NP),
    .IDW     (2),
    .MAX_PKT (MAXP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .grant_id      (grant_id),
    .busy          (busy)
`ifdef UART_TX_ARB_STATS_EN
    ,
    .pkt_count     (pkt_count),
    .force_release (force_release)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_first(input int p, input logic [2:0] v);
    for (int k = 0; k < NP; k++) begin
      if (v[(p + k) % NP]) return (p + k) % NP;
    end
    return 0;
  endfunction

  // Reference model: packet-level arbitration plus byte order queue.
  bit         mon_on = 0;
  bit         md_busy;
  int         md_gid, md_ptr, md_cnt;
  logic [7:0] outq[$];
  logic [7:0] outlog[$];
  bit         prev_hold, prev_acc, exp_fr;
  logic [7:0] prev_data, prev_byte;
  int         md_pktc[NP];

  always @(negedge clk) begin
    logic       ld;
    logic [2:0] exp_rdy;
    logic [2:0] acc;
    if (!rst_n) begin
      md_busy = 0; md_gid = 0; md_ptr = 0; md_cnt = 0;
      outq.delete();
      prev_hold = 0; prev_acc = 0; exp_fr = 0;
      for (int i = 0; i < NP; i++) md_pktc[i] = 0;
    end else if (mon_on) begin
      ld = !mv | mr;
      exp_rdy = '0;
      if (md_busy && ld) exp_rdy[md_gid] = 1'b1;
      check_eq("tready", 32'(tr_obs), 32'(exp_rdy));
      check_eq("busy", 32'(busy), 32'(md_busy));
      if (md_busy) check_eq("grant_id", 32'(grant_id), 32'(md_gid));
      if (prev_hold) begin
        check_eq("hold_valid", 32'(mv), 32'd1);
        check_eq("hold_data", 32'(md), 32'(prev_data));
      end
      if (prev_acc) begin
        check_eq("lat_valid", 32'(mv), 32'd1);
        check_eq("lat_data", 32'(md), 32'(prev_byte));
      end
`ifdef UART_TX_ARB_STATS_EN
      check_eq("force_release", 32'(force_release), 32'(exp_fr));
`endif
      exp_fr = 0;
      if (mv && mr) begin
        if (outq.size() == 0) begin
          check_eq("spurious_out", 32'd1, 32'd0);
        end else begin
          check_eq("out_byte", 32'(md), 32'(outq.pop_front()));
        end
        outlog.push_back(md);
      end
      prev_hold = mv && !mr;
      prev_data = md;
      prev_acc  = 0;
      acc = tv & tr_obs;
      if (md_busy && acc[md_gid]) begin
        prev_acc  = 1;
        prev_byte = td[8*md_gid +: 8];
        outq.push_back(prev_byte);
        md_cnt++;
        if (tl[md_gid] || md_cnt == MAXP) begin
          exp_fr = !tl[md_gid];
          md_pktc[md_gid]++;
          md_ptr  = (md_gid + 1) % NP;
          md_busy = 0;
          md_cnt  = 0;
        end
      end else if (!md_busy && (tv != 0)) begin
        md_gid  = rr_first(md_ptr, tv);
        md_busy = 1;
      end
    end
  end

  // Requester-side driver: per-port beat queues {last, byte}.
  logic [8:0] q[NP][$];
  bit [2:0]   hold;
  bit         rnd_valid = 0;
  bit         rnd_ready = 0;
  bit         rdy_fix   = 1;

  task automatic step();
    logic [2:0] acc;
    @(negedge clk);
    acc = tv & tr_obs;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (acc[i]) begin
        void'(q[i].pop_front());
        hold[i] = 0;
      end
      if (q[i].size() > 0) begin
        if (!hold[i]) hold[i] = rnd_valid ? ($urandom_range(3) != 0) : 1'b1;
        tv[i] = hold[i];
        td[8*i +: 8] = q[i][0][7:0];
        tl[i] = q[i][0][8];
      end else begin
        tv[i] = 0; tl[i] = 0; hold[i] = 0;
      end
    end
    mr = rnd_ready ? ($urandom_range(2) != 0) : rdy_fix;
  endtask

  task automatic push_beat(input int p, input logic [7:0] b, input bit last);
    q[p].push_back({last, b});
  endtask

  task automatic drain(input int limit);
    int n;
    bit idle;
    n = 0;
    idle = 0;
    while (!idle && n < limit) begin
      step();
      n++;
      idle = (q[0].size() == 0) && (q[1].size() == 0) &&
             (q[2].size() == 0) && !mv && !busy && (tv == 0);
    end
    if (!idle) check_eq("drain_timeout", 32'd0, 32'd1);
    repeat (2) step();
  endtask

  // Entered just after a posedge; drops rst_n between clock edges.
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    tv = '0; tl = '0; hold = '0;
    for (int i = 0; i < NP; i++) q[i].delete();
    #1;
    check_eq("rst_tready", 32'(tr_obs), 32'd0);
    check_eq("rst_mvalid", 32'(mv), 32'd0);
    check_eq("rst_mdata", 32'(md), 32'd0);
    check_eq("rst_grant", 32'(grant_id), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    outlog.delete();
  endtask

  task automatic check_log(input string tag, input logic [7:0] exp[$]);
    check_eq({tag, "_len"}, 32'(outlog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < outlog.size(); i++) begin
      check_eq(tag, 32'(outlog[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    logic [7:0] exp[$];
    int         p, len;
    @(posedge clk);
    apply_reset();
    mon_on = 1;

    push_beat(1, 8'h48, 0);
    push_beat(1, 8'h69, 1);
    drain(200);
    exp = '{8'h48, 8'h69};
    check_log("single", exp);

    apply_reset();
    for (int i = 0; i < NP; i++) begin
      push_beat(i, 8'hA0 + 8'(16*i), 0);
      push_beat(i, 8'hA1 + 8'(16*i), 1);
    end
    drain(200);
    exp = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1};
    check_log("contention", exp);

    apply_reset();
    for (int k = 0; k < 3; k++) begin
      push_beat(0, 8'(2*k), 0);
      push_beat(0, 8'(2*k + 1), 1);
    end
    push_beat(2, 8'h20, 0);
    push_beat(2, 8'h21, 1);
    drain(200);
    exp = '{8'h00, 8'h01, 8'h20, 8'h21, 8'h02, 8'h03, 8'h04, 8'h05};
    check_log("fairness", exp);

    outlog.delete();
    for (int k = 0; k < 4; k++) push_beat(1, 8'h50 + 8'(k), k == 3);
    repeat (3) step();
    rdy_fix = 0;
    repeat (11) step();
    rdy_fix = 1;
    drain(200);
    exp = '{8'h50, 8'h51, 8'h52, 8'h53};
    check_log("backpressure", exp);

    apply_reset();
    for (int k = 0; k < 6; k++) push_beat(0, 8'(k), k == 5);
    push_beat(1, 8'h10, 0);
    push_beat(1, 8'h11, 1);
    drain(200);
    exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h04, 8'h05};
    check_log("max_pkt", exp);

    rnd_valid = 1;
    rnd_ready = 1;
    for (int k = 0; k < 60; k++) begin
      p   = $urandom_range(NP - 1);
      len = $urandom_range(6, 1);
      for (int b = 0; b < len; b++) begin
        push_beat(p, {p[1:0], 6'($urandom)}, b == len - 1);
      end
    end
    drain(20000);

    for (int k = 0; k < 5; k++) push_beat(0, 8'h70 + 8'(k), k == 4);
    repeat (4) step();
    apply_reset();
    rnd_valid = 0;
    rnd_ready = 0;
    push_beat(2, 8'h90, 1);
    push_beat(1, 8'h80, 1);
    drain(200);
    exp = '{8'h80, 8'h90};
    check_log("after_reset", exp);

`ifdef UART_TX_ARB_STATS_EN
    for (int i = 0; i < NP; i++) begin
      check_eq("pkt_count", 32'(pkt_count[16*i +: 16]), 32'(md_pktc[i]));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter's AXI-stream byte input between N requesters, e.g. terminal echo path, status reporter and debug dumper.
- Round-robin arbitration at packet granularity: a granted requester keeps the transmitter until its tlast byte is accepted, so messages never interleave on the serial line.
- Sits between the requesters and the uart instance's s_axis_* port, and adds one registered output stage.

Parameters:
- N, 3: number of requesters; legal range 2..8.
- IDW, 2: width of grant index; must satisfy 2**IDW >= N.
- MAX_PKT, 64: byte limit per grant. When this many bytes have been accepted without tlast, the grant is force-released. 0 disables the limit.

Ports:
- clk  in  1  system clock (125 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  8*N  requester bytes; port i uses bits [8i+7:8i].
- s_axis_tvalid  in  N  per-requester valid.
- s_axis_tready  out  N  per-requester ready.
- s_axis_tlast  in  N  per-requester end-of-packet.
- m_axis_tdata  out  8  byte to the uart transmitter.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  uart transmitter ready.
- grant_id  out  IDW  index of the current or last granted requester.
- busy  out  1  high while in GRANT state.

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs and state are zero.
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, grant_id=0, busy=0.
  - State IDLE, round-robin pointer ptr=0, per-grant byte count=0.
- Output register:
  - load = (m_axis_tvalid==0) | m_axis_tready.
  - Only the granted port's s_axis_tready may be high, and only when in GRANT and load=1. All other tready bits are 0.
  - An input beat is accepted when tvalid & tready on the granted port. The byte appears on m_axis_tdata with m_axis_tvalid=1 the next cycle.
  - m_axis_tvalid clears when m_axis_tready=1 and no new beat is accepted in that cycle.
  - m_axis_tdata is stable while m_axis_tvalid=1 and m_axis_tready=0.
- State machine:
  - IDLE: scan ports in order ptr, ptr+1, … wrapping modulo N. Pick the first port with tvalid=1, set grant_id to it, go to GRANT next cycle. No data is accepted in the arbitration cycle, so requester-to-first-tready latency is 1 cycle.
  - GRANT: forward beats from grant_id. Leave GRANT when either of these is accepted:
    - a beat with tlast=1, or
    - the MAX_PKT-th beat (MAX_PKT!=0).
  - On leaving GRANT: ptr <= grant_id+1 (mod N), byte count cleared, return to IDLE.
- Simultaneous events:
  - IDLE may arbitrate while the output register still holds the previous packet's last byte. No bubble is needed beyond the arbitration cycle.
  - A requester that deasserts tvalid mid-packet keeps the grant; the arbiter waits indefinitely, with MAX_PKT only counting accepted beats.
  - A requester with tvalid=1 and tlast=1 on its first beat makes a 1-byte packet: GRANT lasts 1 cycle when load=1.
- Byte count: width clog2(MAX_PKT+1); saturation is impossible by construction.
- N not a power of two: pointer wrap from N-1 goes to 0 explicitly (no modulo by 2**IDW).
- Reset asserted mid-packet: the packet is dropped, the output register is cleared, and the byte is not completed toward the uart.

Optional Feature:
- Macro UART_TX_ARB_STATS_EN.
- When defined, adds these ports:
  - pkt_count (out, 16*N): 16-bit wrapping count per requester of completed grants, incremented on the GRANT→IDLE transition for grant_id.
  - force_release (out, 1): a 1-cycle pulse when a grant ended by the MAX_PKT limit instead of tlast.
  - All of these reset to 0.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package (uart_pkg):
  - state enum (ARB_IDLE, ARB_GRANT);
  - UART_BYTE_W=8;
  - a function computing the next round-robin index with explicit wrap.
- One sub-module: rr_pick.
  - Combinational round-robin priority selector.
  - Inputs: request vector N, pointer IDW.
  - Outputs: found flag and index IDW.
  - Reused later by the VGA character-write scheduler.

Test Plan:
- Single requester: port 1 sends 0x48,0x69(tlast) with m_axis_tready=1 → grant_id=1 one cycle after tvalid; m_axis_tdata emits 0x48 then 0x69 on consecutive cycles; busy falls after 0x69 is accepted; ptr=2.
- Contention: all 3 ports send 2-byte packets (0xA0/0xA1, 0xB0/0xB1, 0xC0/0xC1) from reset → output order A0 A1 B0 B1 C0 C1; no interleave.
- Fairness: port 0 re-requests continuously while port 2 waits → port 2 is granted immediately after port 0's first packet; port 0 is not granted twice in a row.
- Backpressure: m_axis_tready held 0 for 10 cycles mid-packet → m_axis_tdata/tvalid stable; granted tready=0; no byte lost or duplicated after release.
- MAX_PKT=4: port 0 streams 6 bytes without tlast → after 4 accepted bytes the grant moves to waiting port 1; force_release pulses once (STATS build); port 0 resumes later with byte 5.
- Async reset: rst_n pulsed low between clock edges mid-packet → outputs zero immediately; after release, the first grant goes to the lowest requesting port (ptr=0).
